// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- multi-cycle load/store unit
//
// Sits between the core's execute stage and a req/gnt/rvalid data bus. One
// transaction is in flight at a time: a request is captured in IDLE, issued on
// the bus in REQ, its read data awaited in WAIT, and handed back in RESP.
// Handles byte-lane alignment, write-mask generation, load extraction with
// sign/zero extension, illegal-op detection and a bus timeout.
//
// Configuration macro:
//   LSU_MISALIGN_TRAP_EN  defined   : misaligned accesses return err=1 without
//                                     touching the bus
//                         undefined : the address is rounded down to natural
//                                     alignment and the access proceeds
//
// Parameters:
//   XLEN    data width, 32 or 64
//   ADDR_W  byte address width
//   TIMEOUT cycles allowed in REQ+WAIT before an error response, 0 = never
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      core request handshake
//   req_we, req_funct3       store flag and RISC-V size/unsigned encoding
//   req_addr, req_wdata      byte address and LSB-justified store data
//   resp_valid/resp_ready    response handshake back to the core
//   resp_rdata, resp_err     extended load data (0 for stores/errors), error
//   mem_req/mem_gnt          bus request and grant
//   mem_we, mem_addr         bus write enable and word-aligned address
//   mem_wdata, mem_wmask     lane-shifted store data and byte mask
//   mem_rvalid, mem_rdata    bus read data return
// -----------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic              r_we;
  logic [2:0]        r_funct3;
  logic [OFF_W-1:0]  r_off;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [NB-1:0]     r_wmask;
  logic [XLEN-1:0]   r_rdata;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic [1:0]        w_size;
  logic [OFF_W-1:0]  w_lowMask;
  logic [OFF_W-1:0]  w_alignedOff;
  logic [ADDR_W-1:0] w_wordAddr;
  logic [NB-1:0]     w_sizeMask;
  logic [NB-1:0]     w_laneMask;
  logic [XLEN-1:0]   w_laneData;
  logic              w_illegal;
  logic              w_trapMis;
  logic [XLEN-1:0]   w_shifted;
  logic              w_signBit;
  logic [XLEN-1:0]   w_loadData;
  logic              w_timeout;
  logic              w_timeoutFire;

  // Request decode: lane offset, masks and illegal-op detection, all taken
  // straight from the request inputs so they can be captured in IDLE.
  always_comb begin
    w_size    = req_funct3[1:0];
    w_lowMask = '0;
    for (int i = 0; i < OFF_W; i++) begin
      w_lowMask[i] = (i < int'(w_size));
    end
    w_sizeMask = '0;
    for (int i = 0; i < NB; i++) begin
      w_sizeMask[i] = (i < (1 << w_size));
    end
    // Rounding the offset down is a no-op for aligned accesses, and gives
    // natural alignment when misaligned accesses are not trapped.
    w_alignedOff = req_addr[OFF_W-1:0] & ~w_lowMask;
    w_wordAddr   = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    w_laneMask   = w_sizeMask << w_alignedOff;
    w_laneData   = req_wdata << {w_alignedOff, 3'b000};

    w_illegal = 1'b0;
    if ((XLEN == 32) && (w_size == 2'b11)) w_illegal = 1'b1;
    if (req_we && req_funct3[2]) w_illegal = 1'b1;
    if (!req_we && (req_funct3 == 3'b111)) w_illegal = 1'b1;
    if (!req_we && (req_funct3 == 3'b110) && (XLEN == 32)) w_illegal = 1'b1;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misaligned;
  assign w_misaligned = |(req_addr[OFF_W-1:0] & w_lowMask);
  assign w_trapMis    = w_misaligned;
`else
  assign w_trapMis = 1'b0;
`endif

  // Load extraction: shift the addressed bytes down, keep `size` bytes and
  // fill the rest with the sign bit (signed loads) or zero (unsigned loads).
  always_comb begin
    w_shifted = mem_rdata >> {r_off, 3'b000};
    w_signBit = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      if (i == ((8 << r_funct3[1:0]) - 1)) w_signBit = w_shifted[i];
    end
    w_loadData = '0;
    for (int i = 0; i < XLEN; i++) begin
      w_loadData[i] = (i < (8 << r_funct3[1:0])) ? w_shifted[i]
                                                 : (w_signBit & ~r_funct3[2]);
    end
  end

  // The timeout only fires when the bus did not complete the current phase
  // in the same cycle, so a just-in-time grant/rvalid still succeeds.
  always_comb begin
    w_timeout     = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
    w_timeoutFire = w_timeout &&
                    (((r_state == REQ)  && !mem_gnt) ||
                     ((r_state == WAIT) && !mem_rvalid));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and handshake/bus outputs. Bus fields are only driven while a
  // request is outstanding.
  always_comb begin
    w_stateNext = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wmask   = '0;
    resp_rdata  = r_rdata;
    resp_err    = r_err;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_illegal || w_trapMis) w_stateNext = RESP;
          else                        w_stateNext = REQ;
        end
      end
      REQ: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        mem_wmask = r_wmask;
        if (mem_gnt)            w_stateNext = r_we ? RESP : WAIT;
        else if (w_timeoutFire) w_stateNext = RESP;
      end
      WAIT: begin
        if (mem_rvalid || w_timeoutFire) w_stateNext = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Transaction registers: captured on accept, load data latched on rvalid,
  // error forced on timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_off    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wmask  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_off    <= w_alignedOff;
            r_addr   <= w_wordAddr;
            r_wdata  <= req_we ? w_laneData : '0;
            r_wmask  <= req_we ? w_laneMask : '0;
            r_rdata  <= '0;
            r_err    <= w_illegal | w_trapMis;
            r_cnt    <= '0;
          end
        end
        REQ, WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if ((r_state == WAIT) && mem_rvalid) begin
            r_rdata <= w_loadData;
          end else if (w_timeoutFire) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl (XLEN=32, TIMEOUT=4)
//
// A table of single transactions against a zero-wait bus is applied in a loop,
// followed by hand-written sequences for timeout, reset mid-transaction,
// response backpressure and stray bus strobes. Expectations follow
// LSU_MISALIGN_TRAP_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  lsu_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    logic        expBus;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [3:0]  expMask;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
  } vec_t;

  vec_t vecs[$];

  int testsRun    = 0;
  int testsFailed = 0;

  logic        sawReq;
  int          reqCycles;
  int          lat;
  logic        gotResp;
  logic [31:0] obsAddr;
  logic [31:0] obsWdata;
  logic [3:0]  obsMask;
  logic        obsWe;
  logic [31:0] obsRdata;
  logic        obsErr;

  function automatic void addVec(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] mrdata, input logic expBus,
                                 input logic [31:0] expAddr, input logic [31:0] expWdata,
                                 input logic [3:0] expMask, input logic [31:0] expRdata,
                                 input logic expErr, input int expLat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.mrdata = mrdata;
    v.expBus = expBus; v.expAddr = expAddr; v.expWdata = expWdata;
    v.expMask = expMask; v.expRdata = expRdata; v.expErr = expErr; v.expLat = expLat;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Issues one request and follows it until resp_valid, recording the first
  // bus beat, the number of mem_req cycles and the response latency counted
  // in cycles after the accepting edge. Called and returning on a negedge.
  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] mrdata, input logic gnt,
                               input logic rvalid, input logic rready);
    int n;
    sawReq = 1'b0; reqCycles = 0; gotResp = 1'b0;
    obsAddr = '0; obsWdata = '0; obsMask = '0; obsWe = 1'b0;
    obsRdata = '0; obsErr = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    mem_gnt    = gnt;
    mem_rvalid = rvalid;
    mem_rdata  = mrdata;
    resp_ready = rready;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (lat <= 20) begin
      if (mem_req) begin
        if (!sawReq) begin
          obsAddr  = mem_addr;
          obsWdata = mem_wdata;
          obsMask  = mem_wmask;
          obsWe    = mem_we;
        end
        sawReq = 1'b1;
        reqCycles++;
      end
      if (resp_valid) begin
        gotResp  = 1'b1;
        obsRdata = resp_rdata;
        obsErr   = resp_err;
        break;
      end
      @(negedge clk);
      lat++;
    end
    if (!gotResp) checkOutput("respArrived", 64'(gotResp), 64'd1);
    if (rready) begin
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stable;
    int seen;

    // loads against mem_rdata, then stores, then illegal encodings
    addVec(0, 3'b010, 32'h80000004, 32'h0, 32'hDEADBEEF, 1, 32'h80000004, 0, 0, 32'hDEADBEEF, 0, 3);
    addVec(0, 3'b000, 32'h80000003, 32'h0, 32'h80AABBCC, 1, 32'h80000000, 0, 0, 32'hFFFFFF80, 0, 3);
    addVec(0, 3'b100, 32'h80000003, 32'h0, 32'h80AABBCC, 1, 32'h80000000, 0, 0, 32'h00000080, 0, 3);
    addVec(0, 3'b101, 32'h80000002, 32'h0, 32'h80AABBCC, 1, 32'h80000000, 0, 0, 32'h000080AA, 0, 3);
    addVec(0, 3'b001, 32'h80000002, 32'h0, 32'h80AABBCC, 1, 32'h80000000, 0, 0, 32'hFFFF80AA, 0, 3);
    addVec(0, 3'b100, 32'h80000000, 32'h0, 32'h000000FE, 1, 32'h80000000, 0, 0, 32'h000000FE, 0, 3);
    addVec(0, 3'b000, 32'h80000001, 32'h0, 32'h00007F00, 1, 32'h80000000, 0, 0, 32'h0000007F, 0, 3);
    addVec(1, 3'b001, 32'h80000002, 32'h1234, 32'h0, 1, 32'h80000000, 32'h12340000, 4'b1100, 32'h0, 0, 2);
    addVec(1, 3'b000, 32'h80000001, 32'hA5, 32'h0, 1, 32'h80000000, 32'h0000A500, 4'b0010, 32'h0, 0, 2);
    addVec(1, 3'b010, 32'h80000008, 32'hCAFEF00D, 32'h0, 1, 32'h80000008, 32'hCAFEF00D, 4'b1111, 32'h0, 0, 2);
    addVec(0, 3'b011, 32'h80000000, 32'h0, 32'h12345678, 0, 0, 0, 0, 32'h0, 1, 1);
    addVec(1, 3'b100, 32'h80000000, 32'h11, 32'h0, 0, 0, 0, 0, 32'h0, 1, 1);
    addVec(0, 3'b110, 32'h80000000, 32'h0, 32'h12345678, 0, 0, 0, 0, 32'h0, 1, 1);
    addVec(0, 3'b111, 32'h80000000, 32'h0, 32'h12345678, 0, 0, 0, 0, 32'h0, 1, 1);
    addVec(1, 3'b011, 32'h80000000, 32'h22, 32'h0, 0, 0, 0, 0, 32'h0, 1, 1);
`ifdef LSU_MISALIGN_TRAP_EN
    addVec(0, 3'b010, 32'h80000001, 32'h0, 32'h11223344, 0, 0, 0, 0, 32'h0, 1, 1);
    addVec(0, 3'b001, 32'h80000003, 32'h0, 32'h8001ABCD, 0, 0, 0, 0, 32'h0, 1, 1);
    addVec(1, 3'b010, 32'h80000002, 32'h55667788, 32'h0, 0, 0, 0, 0, 32'h0, 1, 1);
`else
    addVec(0, 3'b010, 32'h80000001, 32'h0, 32'h11223344, 1, 32'h80000000, 0, 0, 32'h11223344, 0, 3);
    addVec(0, 3'b001, 32'h80000003, 32'h0, 32'h8001ABCD, 1, 32'h80000000, 0, 0, 32'hFFFF8001, 0, 3);
    addVec(1, 3'b010, 32'h80000002, 32'h55667788, 32'h0, 1, 32'h80000000, 32'h55667788, 4'b1111, 32'h0, 0, 2);
`endif

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0;
    req_wdata = '0; resp_ready = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_resp_err", 64'(resp_err), 64'd0);
    checkOutput("rst_resp_rdata", 64'(resp_rdata), 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                    vecs[i].mrdata, 1'b1, 1'b1, 1'b1);
      checkOutput($sformatf("v%0d_err", i), 64'(obsErr), 64'(vecs[i].expErr));
      checkOutput($sformatf("v%0d_rdata", i), 64'(obsRdata), 64'(vecs[i].expRdata));
      checkOutput($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].expLat));
      checkOutput($sformatf("v%0d_bus", i), 64'(sawReq), 64'(vecs[i].expBus));
      if (vecs[i].expBus) begin
        checkOutput($sformatf("v%0d_mem_addr", i), 64'(obsAddr), 64'(vecs[i].expAddr));
        checkOutput($sformatf("v%0d_mem_we", i), 64'(obsWe), 64'(vecs[i].we));
        if (vecs[i].we) begin
          checkOutput($sformatf("v%0d_mem_wdata", i), 64'(obsWdata), 64'(vecs[i].expWdata));
          checkOutput($sformatf("v%0d_mem_wmask", i), 64'(obsMask), 64'(vecs[i].expMask));
        end
      end
      checkOutput($sformatf("v%0d_ready_after", i), 64'(req_ready), 64'd1);
    end

    // timeout while waiting for grant: 4 cycles of mem_req, then error
    applyStimulus(1'b0, 3'b010, 32'h80000010, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("toReq_cycles", 64'(reqCycles), 64'd4);
    checkOutput("toReq_latency", 64'(lat), 64'd5);
    checkOutput("toReq_err", 64'(obsErr), 64'd1);
    checkOutput("toReq_rdata", 64'(obsRdata), 64'd0);

    // late rvalid after the timeout response must be ignored
    mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (resp_valid || mem_req || !req_ready) seen++;
    end
    checkOutput("lateRvalid_ignored", 64'(seen), 64'd0);
    mem_rvalid = 1'b0;
    applyStimulus(1'b0, 3'b010, 32'h80000020, 32'h0, 32'h13579BDF, 1'b1, 1'b1, 1'b1);
    checkOutput("afterTo_rdata", 64'(obsRdata), 64'h13579BDF);
    checkOutput("afterTo_err", 64'(obsErr), 64'd0);

    // timeout while waiting for read data after a grant
    applyStimulus(1'b0, 3'b010, 32'h80000030, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("toWait_latency", 64'(lat), 64'd5);
    checkOutput("toWait_err", 64'(obsErr), 64'd1);
    checkOutput("toWait_reqCycles", 64'(reqCycles), 64'd1);

    // reset asserted in WAIT: no response afterwards even with rvalid
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80000040;
    mem_gnt = 1'b1; mem_rvalid = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rstWait_inWait", 64'({mem_req, resp_valid, req_ready}), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA5555;
    checkOutput("rstWait_mem_req", 64'(mem_req), 64'd0);
    checkOutput("rstWait_ready", 64'(req_ready), 64'd1);
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checkOutput("rstWait_noResp", 64'(seen), 64'd0);
    mem_rvalid = 1'b0;

    // reset asserted in REQ: mem_req drops on the next cycle
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h80000050;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rstReq_inReq", 64'(mem_req), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstReq_mem_req", 64'(mem_req), 64'd0);
    checkOutput("rstReq_resp_valid", 64'(resp_valid), 64'd0);

    // response backpressure: rdata/err held while resp_ready stays low
    applyStimulus(1'b0, 3'b010, 32'h80000004, 32'h0, 32'h0BADF00D, 1'b1, 1'b1, 1'b0);
    checkOutput("bp_latency", 64'(lat), 64'd3);
    mem_rdata = 32'hFFFFFFFF;
    stable = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (resp_valid && (resp_rdata == 32'h0BADF00D) && !resp_err && !req_ready) stable++;
    end
    checkOutput("bp_stable", 64'(stable), 64'd3);
    resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_released", 64'({resp_valid, req_ready}), 64'b01);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;

    // stray grant/rvalid while idle
    mem_gnt = 1'b1; mem_rvalid = 1'b1;
    seen = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (mem_req || resp_valid) seen++;
    end
    checkOutput("stray_ignored", 64'(seen), 64'd0);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Multi-cycle load/store unit between the core's execute stage and the data memory bus.
- Replaces the single-cycle combinational memory access path with a req/gnt/rvalid bus master.
- Performs byte-lane alignment, write-mask generation, read extraction with sign/zero extension, illegal-op and misalignment checks, and a bus timeout.
- Generalised over data width (32/64) and response timeout.

Parameters:
XLEN, 32, data width; legal values 32 or 64.
ADDR_W, 32, address width.
TIMEOUT, 256, max cycles spent in REQ+WAIT before error; 0 disables timeout.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_valid  in  1  core request valid
req_ready  out  1  LSU can accept a request
req_we  in  1  1=store, 0=load
req_funct3  in  3  RISC-V funct3 (size[1:0], unsigned bit [2])
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, LSB-justified
resp_valid  out  1  response valid
resp_ready  in  1  core accepts response
resp_rdata  out  XLEN  extended load data; 0 for stores and errors
resp_err  out  1  illegal op, misalignment or timeout
mem_req  out  1  bus request
mem_gnt  in  1  bus grant
mem_we  out  1  bus write enable
mem_addr  out  ADDR_W  word-aligned address (low log2(XLEN/8) bits zero)
mem_wdata  out  XLEN  lane-shifted write data
mem_wmask  out  XLEN/8  byte write mask
mem_rvalid  in  1  read data valid
mem_rdata  in  XLEN  read data, full bus word

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. Reset puts the FSM in IDLE. All registered outputs reset to 0. req_ready = (state==IDLE), so it is 1 on the first cycle after reset.
- IDLE:
  - On req_valid, capture we, funct3, addr and wdata.
  - Illegal op goes directly to RESP with err=1 and no bus access. Illegal ops: funct3 size=11 when XLEN=32; store with funct3[2]=1; load 111; load 110 when XLEN=32.
  - Otherwise go to REQ.
- Misalignment: addr mod size ≠ 0. Handling is set by LSU_MISALIGN_TRAP_EN.
- REQ:
  - mem_req=1, with mem_we/addr/wdata/wmask held stable until mem_gnt.
  - On gnt, a store goes to RESP and a load goes to WAIT.
  - mem_rvalid in the gnt cycle is ignored.
- WAIT: on mem_rvalid, latch extracted data and go to RESP.
- RESP:
  - resp_valid=1, with rdata and err held until resp_ready; then go to IDLE.
  - Next request is accepted one cycle later; no overlap.
- Minimum latency with zero-wait bus (accept at edge 0):
  - Load: REQ cycle 1, WAIT cycle 2 (rvalid), resp_valid cycle 3.
  - Store: resp_valid cycle 2.
- Lane rules (off = addr low bits):
  - wmask = size-ones (1/3/F/FF) << off.
  - wdata = req_wdata << 8*off.
  - rdata = mem_rdata >> 8*off, truncated to size, then sign-extended if funct3[2]=0, else zero-extended.
- Timeout:
  - Counter clears on entering REQ and increments each cycle in REQ/WAIT.
  - Reaching TIMEOUT deasserts mem_req and goes to RESP with err=1, rdata=0.
  - A late rvalid is ignored.
- Stray handling: mem_gnt outside REQ and mem_rvalid outside WAIT are ignored.
- Reset mid-transaction: the transaction is abandoned, mem_req is 0 on the next cycle, and no response is issued.

Optional Feature:
LSU_MISALIGN_TRAP_EN:
- Defined: a misaligned access goes IDLE→RESP with err=1 and no bus access.
- Undefined: address low bits are forced to natural alignment (addr & ~(size-1)), the access proceeds normally, and err=0.

Test Plan:
- lw addr=0x80000004, mem_rdata=0xDEADBEEF, gnt/rvalid immediate → mem_addr=0x80000004, resp_rdata=0xDEADBEEF at cycle 3, err=0.
- lb addr=0x80000003, mem_rdata=0x80AABBCC → rdata=0xFFFFFF80; lbu same → 0x00000080; lhu addr=0x80000002 → 0x000080AA.
- sh addr=0x80000002, wdata=0x1234 → mem_wmask=4'b1100, mem_wdata=0x12340000, mem_we=1; resp_valid cycle 2, rdata=0.
- lw addr=0x80000001: with macro → err=1, mem_req never asserted; without macro → mem_addr=0x80000000, normal load.
- TIMEOUT=4, mem_gnt held 0 → mem_req high for 4 cycles, then resp_err=1; a later rvalid is ignored and the next request is accepted cleanly.
- rst asserted in WAIT, then rvalid → no resp_valid, req_ready=1 after reset; resp_ready held 0 for 3 cycles → resp stable, then IDLE.
